// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 definitions for the compression engine.
//   word_t          32-bit word type
//   state_t         compression FSM states
//   K / IV          round constants and initial hash value
//   ssig0/ssig1     small-sigma message-schedule functions
//   ch/maj          round choice and majority functions
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word sliding message-schedule window.
//   clk, rst_n  clock / async active-low reset
//   load        capture block_in as W0..W15
//   shift       advance window one word, appending the next expanded word
//   block_in    512-bit block, W0 in bits [511:480]
//   w_t         current round word (window head)
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] block_in,
  output word_t        w_t
);

  word_t win_q [16];
  word_t win_d [16];
  word_t w_next;

  // Window holds W[t..t+15]; W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
  always_comb begin
    w_next = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
    if (load) begin
      for (int i = 0; i < 16; i++) win_d[i] = block_in[511-32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  assign w_t = win_q[0];

endmodule

// File: rtl/summation_0.sv
// summation_0: SHA-256 big-sigma 0, y = ROTR2(x) ^ ROTR13(x) ^ ROTR22(x).
//   x  input  32  working register a
//   y  output 32  Sigma0(a)
module summation_0 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
endmodule

// File: rtl/summation_1.sv
// summation_1: SHA-256 big-sigma 1, y = ROTR6(x) ^ ROTR11(x) ^ ROTR25(x).
//   x  input  32  working register e
//   y  output 32  Sigma1(e)
module summation_1 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: iterative SHA-256 compression, one round per clock.
//   clk, rst_n  clock / async active-low reset
//   start       compress block_in (accepted only in IDLE)
//   first       with start: 1 = chain from IV, 0 = chain from digest
//   block_in    512-bit pre-padded block, W0 in bits [511:480]
//   busy        high in ROUND and FINAL
//   done        one-cycle pulse after digest is updated
//   digest      chaining value, H0 in bits [255:224]
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         first,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  state_t         state_q, state_d;
  logic [5:0]     t_q, t_d;
  word_t          wv_q [8];   // working registers a..h
  word_t          wv_d [8];
  word_t          hc_q [8];   // chaining value the block started from
  word_t          hc_d [8];
  logic [255:0]   digest_q, digest_d;
  logic           done_q, done_d;
  logic           sched_load, sched_shift;
  word_t          w_t, big_s0, big_s1, t1, t2, h_init;

  summation_0 u_sum0 (.x(wv_q[0]), .y(big_s0));
  summation_1 u_sum1 (.x(wv_q[4]), .y(big_s1));

  sha256_msg_sched u_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sched_load),
    .shift    (sched_shift),
    .block_in (block_in),
    .w_t      (w_t)
  );

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    digest_d    = digest_q;
    done_d      = 1'b0;
    sched_load  = 1'b0;
    sched_shift = 1'b0;
    h_init      = '0;
    for (int i = 0; i < 8; i++) begin
      wv_d[i] = wv_q[i];
      hc_d[i] = hc_q[i];
    end
    t1 = wv_q[7] + big_s1 + ch(wv_q[4], wv_q[5], wv_q[6]) + K[t_q] + w_t;
    t2 = big_s0 + maj(wv_q[0], wv_q[1], wv_q[2]);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < 8; i++) begin
            h_init  = first ? IV[i] : digest_q[255-32*i -: 32];
            hc_d[i] = h_init;
            wv_d[i] = h_init;
          end
          sched_load = 1'b1;
          t_d        = '0;
          state_d    = S_ROUND;
        end
      end
      S_ROUND: begin
        wv_d[7] = wv_q[6];
        wv_d[6] = wv_q[5];
        wv_d[5] = wv_q[4];
        wv_d[4] = wv_q[3] + t1;
        wv_d[3] = wv_q[2];
        wv_d[2] = wv_q[1];
        wv_d[1] = wv_q[0];
        wv_d[0] = t1 + t2;
        sched_shift = 1'b1;
        // Counter parks on the last round instead of wrapping.
        if (t_q == 6'(ROUNDS - 1)) state_d = S_FINAL;
        else                       t_d = t_q + 6'd1;
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) digest_d[255-32*i -: 32] = hc_q[i] + wv_q[i];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      digest_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        wv_q[i] <= '0;
        hc_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      digest_q <= digest_d;
      done_q   <= done_d;
      for (int i = 0; i < 8; i++) begin
        wv_q[i] <= wv_d[i];
        hc_q[i] <= hc_d[i];
      end
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign digest = digest_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress using known SHA-256 digests.
module tb_sha256_compress;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         first = 1'b0;
  logic [511:0] block_in = '0;
  logic         busy, done;
  logic [255:0] digest;

  sha256_compress dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .first    (first),
    .block_in (block_in),
    .busy     (busy),
    .done     (done),
    .digest   (digest)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mutex_viol = 0;
  int done_seen = 0;

  always @(negedge clk) begin
    if (busy && done) mutex_viol++;
    if (done) done_seen++;
  end

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  // 56-byte message: the 0x80 pad byte still fits in block 1; block 2 carries only the length.
  localparam logic [511:0] BLK_2A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B = {480'h0, 32'h000001c0};

  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  typedef struct {
    string        name;
    logic [511:0] blk;
    logic         first;
    logic [255:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Presents start now; returns the number of edges after the accepting edge
  // until done is seen (-1 on timeout). Returns #1 after the done edge.
  task automatic run_block(input logic [511:0] blk, input logic f, output int lat);
    start    = 1'b1;
    block_in = blk;
    first    = f;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  vec_t vecs [3];
  int   lat;
  int   done_before;

  initial begin
    vecs[0] = '{"abc",   BLK_ABC,   1'b1, D_ABC};
    vecs[1] = '{"empty", BLK_EMPTY, 1'b1, D_EMPTY};
    vecs[2] = '{"abc2",  BLK_ABC,   1'b1, D_ABC};

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",   256'(busy),   256'd0);
    check("reset_done",   256'(done),   256'd0);
    check("reset_digest", digest,       256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven single-block vectors.
    for (int v = 0; v < 3; v++) begin
      run_block(vecs[v].blk, vecs[v].first, lat);
      check({vecs[v].name, "_latency"}, 256'(lat), 256'd65);
      check({vecs[v].name, "_digest"},  digest,    vecs[v].exp);
      check({vecs[v].name, "_busy_in_done"}, 256'(busy), 256'd0);
      @(posedge clk); #1;
    end

    // start while busy (round 10, round 63, FINAL edge) is ignored.
    done_before = done_seen;
    start = 1'b1; block_in = BLK_ABC; first = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      start    = (k == 11 || k == 64 || k == 65);
      block_in = BLK_EMPTY;
      first    = 1'b1;
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("ignore_latency", 256'(lat), 256'd65);
    check("ignore_digest",  digest,    D_ABC);
    check("ignore_done_cnt", 256'(done_seen - done_before), 256'd1);
    check("ignore_idle",    256'(busy), 256'd0);

    // Reset in the middle of round 30.
    start = 1'b1; block_in = BLK_EMPTY; first = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_before = done_seen;
    repeat (30) @(posedge clk);
    #1;
    check("midrun_busy", 256'(busy), 256'd1);
    rst_n = 1'b0;
    #1;
    check("rst_busy",   256'(busy), 256'd0);
    check("rst_done",   256'(done), 256'd0);
    check("rst_digest", digest,     256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_done", 256'(done_seen - done_before), 256'd0);
    run_block(BLK_ABC, 1'b1, lat);
    check("post_rst_latency", 256'(lat), 256'd65);
    check("post_rst_digest",  digest,    D_ABC);

    // Two-block message, second start issued in the done cycle.
    @(posedge clk); #1;
    run_block(BLK_2A, 1'b1, lat);
    check("two_a_latency", 256'(lat), 256'd65);
    check("two_a_done",    256'(done), 256'd1);
    run_block(BLK_2B, 1'b0, lat);
    check("two_b_latency", 256'(lat), 256'd65);
    check("two_b_digest",  digest,    D_TWO);

    // Digest must hold in IDLE with random inputs and start low.
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < 16; i++) block_in[32*i +: 32] = $urandom();
      first = 1'($urandom());
      start = 1'b0;
      @(posedge clk); #1;
      check("idle_hold", digest, D_TWO);
    end
    check("idle_busy", 256'(busy), 256'd0);
    check("busy_done_mutex", 256'(mutex_viol), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
